// File: rtl/instr_transmit_if.sv
// ----------------------------------------------------------------------------
// instr_transmit_if
// Purpose : stream bus between the instruction ROM transmitter and its
//           consumer (instruction fetch / receive path).
// Signals :
//   t_i_syn   consumer -> transmitter, "send next word" request
//   t_o_instr transmitter -> consumer, instruction word (registered)
//   t_o_last  transmitter -> consumer, marks the final program word
//   t_o_ack   transmitter -> consumer, marks a newly sent valid word
// Modports:
//   master : transmitter side (drives the word, last and ack)
//   slave  : consumer side (drives the request)
// ----------------------------------------------------------------------------
`ifndef IWIDTH
`define IWIDTH 32
`endif

interface instr_transmit_if #(
    parameter int unsigned IWIDTH = `IWIDTH
);
    logic              t_i_syn;
    logic [IWIDTH-1:0] t_o_instr;
    logic              t_o_last;
    logic              t_o_ack;

    modport master (
        input  t_i_syn,
        output t_o_instr,
        output t_o_last,
        output t_o_ack
    );

    modport slave (
        output t_i_syn,
        input  t_o_instr,
        input  t_o_last,
        input  t_o_ack
    );
endinterface

// File: rtl/instr_transmit.sv
// ----------------------------------------------------------------------------
// instr_transmit
// Purpose : instruction-stream source for the MIPS core. Holds a small fixed
//           program ROM and streams one word per clock while the consumer
//           holds the sync request. Each sent word is flagged with ack, the
//           final program word additionally with last.
// Ports   :
//   t_clk  clock, rising edge
//   t_rst  synchronous reset, active-low
//   bus    instr_transmit_if.master (t_i_syn in; t_o_instr/t_o_last/t_o_ack out)
// Options :
//   TRANSMIT_LOOP_EN  when defined the stream wraps to word 0 after the last
//                     word and keeps going; otherwise the stream is one-shot
//                     and waits in DONE until the request is dropped.
// ----------------------------------------------------------------------------
`ifndef IWIDTH
`define IWIDTH 32
`endif

module instr_transmit #(
    parameter int unsigned IWIDTH = `IWIDTH,
    parameter int unsigned DEPTH  = 6,
    parameter int unsigned AWIDTH = 3
) (
    input  logic                t_clk,
    input  logic                t_rst,
    instr_transmit_if.master    bus
);

    localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);

`ifdef TRANSMIT_LOOP_EN
    typedef enum logic {
        ST_SEND = 1'b0
    } state_t;
`else
    typedef enum logic {
        ST_SEND = 1'b0,
        ST_DONE = 1'b1
    } state_t;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AWIDTH-1:0] r_ptr;
    logic [AWIDTH-1:0] w_ptr_nxt;
    logic [IWIDTH-1:0] r_instr;
    logic [IWIDTH-1:0] w_instr_nxt;
    logic              r_ack;
    logic              w_ack_nxt;
    logic              r_last;
    logic              w_last_nxt;
    logic              w_ptr_at_last;
    logic [IWIDTH-1:0] w_rom_word;

    // Fixed program image; anything beyond the six real words reads as zero.
    function automatic logic [IWIDTH-1:0] rom_word(input logic [AWIDTH-1:0] idx);
        logic [IWIDTH-1:0] word;
        case (int'(idx))
            0:       word = IWIDTH'(32'h2008_0005);
            1:       word = IWIDTH'(32'h2009_000A);
            2:       word = IWIDTH'(32'h0109_5020);
            3:       word = IWIDTH'(32'h0109_5822);
            4:       word = IWIDTH'(32'hAC0A_0000);
            5:       word = IWIDTH'(32'h8C0C_0000);
            default: word = '0;
        endcase
        return word;
    endfunction

    assign w_rom_word    = rom_word(r_ptr);
    assign w_ptr_at_last = (r_ptr == LAST_IDX);

    // State, pointer and output registers.
    always_ff @(posedge t_clk) begin
        if (!t_rst) begin
            r_state <= ST_SEND;
            r_ptr   <= '0;
            r_instr <= '0;
            r_ack   <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_instr <= w_instr_nxt;
            r_ack   <= w_ack_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state and next-output logic. The word register holds by default,
    // ack/last are single-cycle strobes that fall back to zero.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_instr_nxt = r_instr;
        w_ack_nxt   = 1'b0;
        w_last_nxt  = 1'b0;

        case (r_state)
            ST_SEND: begin
                if (bus.t_i_syn) begin
                    w_instr_nxt = w_rom_word;
                    w_ack_nxt   = 1'b1;
                    w_last_nxt  = w_ptr_at_last;
                    if (w_ptr_at_last) begin
                        w_ptr_nxt = '0;
`ifndef TRANSMIT_LOOP_EN
                        w_state_nxt = ST_DONE;
`endif
                    end else begin
                        w_ptr_nxt = r_ptr + AWIDTH'(1);
                    end
                end
            end
`ifndef TRANSMIT_LOOP_EN
            // Wait for the consumer to drop the request before re-arming;
            // the re-arming edge itself emits nothing.
            ST_DONE: begin
                if (!bus.t_i_syn) begin
                    w_state_nxt = ST_SEND;
                    w_ptr_nxt   = '0;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_SEND;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign bus.t_o_instr = r_instr;
    assign bus.t_o_ack   = r_ack;
    assign bus.t_o_last  = r_last;

endmodule

// File: tb/tb_instr_transmit.sv
// ----------------------------------------------------------------------------
// tb_instr_transmit
// Directed stimulus for instr_transmit: reset, full stream, restart after
// DONE (or wrap-around with TRANSMIT_LOOP_EN), pause/resume, and reset
// in the middle of a stream.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_instr_transmit;

    logic t_clk;
    logic t_rst;
    int   n_tests;
    int   n_fail;

    logic [31:0] exp_rom [6];

    instr_transmit_if #(.IWIDTH(32)) bus ();

    instr_transmit #(
        .IWIDTH (32),
        .DEPTH  (6),
        .AWIDTH (3)
    ) dut (
        .t_clk (t_clk),
        .t_rst (t_rst),
        .bus   (bus)
    );

    initial t_clk = 1'b0;
    always #5 t_clk = ~t_clk;

    // Drive the request, take one rising edge, then sample 1 ns later.
    task automatic tick(input logic syn);
        bus.t_i_syn = syn;
        @(posedge t_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e_instr,
                           input logic e_ack, input logic e_last);
        chk({tag, ".instr"}, bus.t_o_instr, e_instr);
        chk({tag, ".ack"},   32'(bus.t_o_ack),  32'(e_ack));
        chk({tag, ".last"},  32'(bus.t_o_last), 32'(e_last));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_rom[0] = 32'h2008_0005;
        exp_rom[1] = 32'h2009_000A;
        exp_rom[2] = 32'h0109_5020;
        exp_rom[3] = 32'h0109_5822;
        exp_rom[4] = 32'hAC0A_0000;
        exp_rom[5] = 32'h8C0C_0000;

        // Reset for two edges; request high on the second shows reset priority.
        t_rst = 1'b0;
        tick(1'b0);
        chk_out("reset0", 32'h0, 1'b0, 1'b0);
        tick(1'b1);
        chk_out("reset1", 32'h0, 1'b0, 1'b0);
        t_rst = 1'b1;

        // Full stream, last only on the sixth word.
        for (int i = 0; i < 6; i++) begin
            tick(1'b1);
            chk_out($sformatf("stream%0d", i), exp_rom[i], 1'b1, (i == 5));
        end

`ifdef TRANSMIT_LOOP_EN
        tick(1'b1);
        chk_out("wrap0", exp_rom[0], 1'b1, 1'b0);
        tick(1'b1);
        chk_out("wrap1", exp_rom[1], 1'b1, 1'b0);
`else
        tick(1'b1);
        chk_out("done_hold", exp_rom[5], 1'b0, 1'b0);
        tick(1'b1);
        chk_out("done_hold2", exp_rom[5], 1'b0, 1'b0);
        // Dropping the request re-arms without emitting a word.
        tick(1'b0);
        chk_out("rearm", exp_rom[5], 1'b0, 1'b0);
        tick(1'b1);
        chk_out("restart0", exp_rom[0], 1'b1, 1'b0);
        tick(1'b1);
        chk_out("restart1", exp_rom[1], 1'b1, 1'b0);
`endif

        // Reset back to a known start.
        t_rst = 1'b0;
        tick(1'b1);
        chk_out("reset2", 32'h0, 1'b0, 1'b0);
        t_rst = 1'b1;

        // Pause and resume.
        tick(1'b1);
        chk_out("pause_w0", exp_rom[0], 1'b1, 1'b0);
        tick(1'b1);
        chk_out("pause_w1", exp_rom[1], 1'b1, 1'b0);
        tick(1'b0);
        chk_out("pause_hold0", exp_rom[1], 1'b0, 1'b0);
        tick(1'b0);
        chk_out("pause_hold1", exp_rom[1], 1'b0, 1'b0);
        tick(1'b1);
        chk_out("resume_w2", exp_rom[2], 1'b1, 1'b0);

        // Reset mid-stream after three words aborts the stream.
        t_rst = 1'b0;
        tick(1'b1);
        chk_out("midreset", 32'h0, 1'b0, 1'b0);
        t_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1);
            chk_out($sformatf("after_rst%0d", i), exp_rom[i], 1'b1, (i == 5));
        end

`ifdef TRANSMIT_LOOP_EN
        tick(1'b1);
        chk_out("after_rst_wrap", exp_rom[0], 1'b1, 1'b0);
`else
        tick(1'b1);
        chk_out("after_rst_done", exp_rom[5], 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_transmit.md
Name: instr_transmit

Overview:
- Instruction-stream source for the MIPS core.
- Holds a small fixed instruction ROM and streams it out one word per clock while the consumer asserts the sync request.
- Flags each valid word with an acknowledge, and flags the final program word with last.
- Sits ahead of the instruction-fetch/receive path and acts as a program loader for simulation and bring-up.

Parameters:
- IWIDTH, 32, instruction word width; the codebase macro `IWIDTH sets the port width.
- DEPTH, 6, number of program words in the ROM; must be at least 2.
- AWIDTH, 3, read-pointer width; must satisfy 2**AWIDTH >= DEPTH.

Ports:
- t_clk  input  1  clock; all logic updates on the rising edge.
- t_rst  input  1  synchronous reset, active-low.
- t_i_syn  input  1  stream request; high means "send next word".
- t_o_instr  output  IWIDTH  current instruction word (registered).
- t_o_last  output  1  high for the cycle that carries the final ROM word.
- t_o_ack  output  1  high when t_o_instr carries a newly sent valid word.

Behaviour:
- Reset (t_rst==0 at a rising edge): t_o_instr=0, t_o_ack=0, t_o_last=0, pointer ptr=0, state=SEND.
- ROM contents, fixed and index 0 first:
  - 0x20080005, 0x2009000A, 0x01095020, 0x01095822, 0xAC0A0000, 0x8C0C0000.
  - Indices >= 6 (if DEPTH is raised) read 0x00000000.
- States: SEND and DONE.
- SEND with t_i_syn=1 at an edge:
  - t_o_instr<=rom[ptr], t_o_ack<=1, t_o_last<=(ptr==DEPTH-1).
  - If ptr==DEPTH-1: ptr<=0 and state<=DONE; otherwise ptr<=ptr+1.
- SEND with t_i_syn=0:
  - t_o_ack<=0, t_o_last<=0.
  - t_o_instr holds its last value; ptr holds, so the stream pauses and resumes with the next word.
- DONE:
  - t_o_ack<=0, t_o_last<=0, t_o_instr holds the last word.
  - Stays in DONE while t_i_syn=1.
  - On the first edge with t_i_syn=0, returns to SEND with ptr=0; no word is emitted on that edge.
- Latency: a word appears on the outputs one clock after the edge that samples t_i_syn=1. t_o_ack and t_o_last are aligned with that word.
- t_o_last is never high without t_o_ack.
- Reset has priority over all other activity. Reset mid-stream aborts the stream: next request starts at index 0.
- No combinational path from t_i_syn to any output.

Optional Feature:
- Macro TRANSMIT_LOOP_EN.
- When defined: no DONE state. After the last word, ptr wraps to 0 and streaming continues with rom[0] on the next requested cycle. t_o_last still pulses on each DEPTH-1 word.
- When undefined: one-shot behaviour with DONE, as described above.

Test Plan:
- Reset: hold t_rst=0 for 2 edges -> t_o_instr=0, t_o_ack=0, t_o_last=0.
- Full stream: t_i_syn=1 for 7 edges after reset. Required response:
  - Edges 1-6 give 20080005, 2009000A, 01095020, 01095822, AC0A0000, 8C0C0000 with ack=1.
  - last=1 only on the 6th word.
  - Edge 7 gives ack=0, last=0, instr holds 8C0C0000.
- Pause: syn=1 for 2 edges, 0 for 2 edges, 1 again. Required response:
  - Words 20080005, 2009000A, then ack=0 with instr held at 2009000A.
  - Stream resumes with 01095020.
- Restart: after DONE, drop syn for 1 edge then raise it -> first word is 20080005 again with ack=1.
- Reset mid-stream: after 3 words, pulse t_rst=0 for 1 edge, then syn=1 -> outputs cleared, next word is 20080005.
- With TRANSMIT_LOOP_EN: syn=1 for 8 edges -> 7th and 8th words are 20080005 and 2009000A; last=1 only on the 6th.
